// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the shared 32-bit ALU: maps operands per opcode, runs one or two passes,
// owns the NZCV flag register and returns results on a held valid/ready response channel.
module alu_seq_ctrl #(
    parameter int         CNT_W    = 16,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_s,
    input  logic [63:0]      cmd_a,
    input  logic [63:0]      cmd_b,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    output logic             alu_carry,
    output logic [1:0]       alu_op,
    input  logic [31:0]      alu_out,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic             rsp_wb,
    output logic             rsp_err,
    output logic [3:0]       flag_nzcv,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXEC_LO = 2'd1;
    localparam logic [1:0] S_EXEC_HI = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [2:0] OP_ADC   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_ROR   = 3'd4;
    localparam logic [2:0] OP_ADD64 = 3'd5;
    localparam logic [2:0] OP_CMP   = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             s_q, s_d;
    logic [63:0]      a_q, a_d;
    logic [63:0]      b_q, b_d;
    logic             cin_q, cin_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             c_lo_q, c_lo_d;
    logic             z_lo_q, z_lo_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [63:0]      rsp_result_q, rsp_result_d;
    logic             rsp_wb_q, rsp_wb_d;
    logic             rsp_err_q, rsp_err_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_wb     = rsp_wb_q;
    assign rsp_err    = rsp_err_q;
    assign flag_nzcv  = flags_q;
    assign ops_done   = ops_done_q;

    // ALU inputs are non-zero only while a pass is in flight.
    always_comb begin
        alu_in1   = '0;
        alu_in2   = '0;
        alu_carry = 1'b0;
        alu_op    = 2'b00;
        if (state_q == S_EXEC_LO) begin
            case (op_q)
                OP_SUB, OP_CMP: begin
                    alu_in1 = b_q[31:0];
                    alu_in2 = a_q[31:0];
                    alu_op  = 2'b01;
                end
                OP_AND: begin
                    alu_in1 = a_q[31:0];
                    alu_in2 = b_q[31:0];
                    alu_op  = 2'b10;
                end
                OP_ROR: begin
                    alu_in1 = {27'b0, b_q[4:0]};
                    alu_in2 = a_q[31:0];
                    alu_op  = 2'b11;
                end
                default: begin
                    alu_in1   = a_q[31:0];
                    alu_in2   = b_q[31:0];
                    alu_carry = (op_q == OP_ADC) & cin_q;
                end
            endcase
        end else if (state_q == S_EXEC_HI) begin
            alu_in1   = a_q[63:32];
            alu_in2   = b_q[63:32];
            alu_carry = c_lo_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        s_d          = s_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        res_lo_d     = res_lo_q;
        c_lo_d       = c_lo_q;
        z_lo_d       = z_lo_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_wb_d     = rsp_wb_q;
        rsp_err_d    = rsp_err_q;
        flags_d      = flags_q;
        ops_done_d   = ops_done_q;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                op_d  = cmd_op;
                s_d   = cmd_s;
                a_d   = cmd_a;
                b_d   = cmd_b;
                cin_d = flags_q[1];
                if (cmd_op == OP_ILL) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = '0;
                    rsp_wb_d     = 1'b0;
                    rsp_err_d    = 1'b1;
                end else begin
                    state_d = S_EXEC_LO;
                end
            end
            S_EXEC_LO: begin
                if (op_q == OP_ADD64) begin
                    state_d  = S_EXEC_HI;
                    res_lo_d = alu_out;
                    c_lo_d   = alu_c;
                    z_lo_d   = alu_z;
                end else begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = {32'b0, alu_out};
                    rsp_wb_d     = (op_q != OP_CMP);
                    rsp_err_d    = 1'b0;
                    // AND preserves C,V; ROR preserves V.
                    if (s_q || op_q == OP_CMP) begin
                        case (op_q)
                            OP_AND:  flags_d = {alu_n, alu_z, flags_q[1:0]};
                            OP_ROR:  flags_d = {alu_n, alu_z, alu_c, flags_q[0]};
                            default: flags_d = {alu_n, alu_z, alu_c, alu_v};
                        endcase
                    end
                end
            end
            S_EXEC_HI: begin
                state_d      = S_RESP;
                rsp_valid_d  = 1'b1;
                rsp_result_d = {alu_out, res_lo_q};
                rsp_wb_d     = 1'b1;
                rsp_err_d    = 1'b0;
                if (s_q) flags_d = {alu_n, alu_z & z_lo_q, alu_c, alu_v};
            end
            default: if (rsp_ready) begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                ops_done_d  = ops_done_q + CNT_W'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            s_q          <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            res_lo_q     <= '0;
            c_lo_q       <= 1'b0;
            z_lo_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_wb_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            flags_q      <= FLAG_RST;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            s_q          <= s_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            res_lo_q     <= res_lo_d;
            c_lo_q       <= c_lo_d;
            z_lo_q       <= z_lo_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_wb_q     <= rsp_wb_d;
            rsp_err_q    <= rsp_err_d;
            flags_q      <= flags_d;
            ops_done_q   <= ops_done_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU on the ALU port, plus an arithmetic reference model
// of results, flags, latency and counter; directed cases then randomized commands.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_s;
    logic [2:0]  cmd_op;
    logic [63:0] cmd_a, cmd_b;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_carry, alu_n, alu_z, alu_c, alu_v;
    logic [1:0]  alu_op;
    logic        rsp_valid, rsp_ready, rsp_wb, rsp_err;
    logic [63:0] rsp_result;
    logic [3:0]  flag_nzcv;
    logic [15:0] ops_done;

    int          n_chk = 0;
    int          n_err = 0;
    logic [3:0]  mflags;
    logic [15:0] mops;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.CNT_W(16), .FLAG_RST(4'b0000)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_s(cmd_s),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_carry(alu_carry), .alu_op(alu_op),
        .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_wb(rsp_wb), .rsp_err(rsp_err), .flag_nzcv(flag_nzcv), .ops_done(ops_done)
    );

    // Shared ALU: SUB is in2-in1 with C = no borrow; ROR sets C from result bit 31.
    logic [32:0] alu_t;
    always_comb begin
        alu_t   = '0;
        alu_out = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            2'b00: begin
                alu_t   = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'b0, alu_carry};
                alu_out = alu_t[31:0];
                alu_c   = alu_t[32];
                alu_v   = (alu_in1[31] == alu_in2[31]) && (alu_out[31] != alu_in1[31]);
            end
            2'b01: begin
                alu_out = alu_in2 - alu_in1;
                alu_c   = (alu_in2 >= alu_in1);
                alu_v   = (alu_in1[31] != alu_in2[31]) && (alu_out[31] != alu_in2[31]);
            end
            2'b10: alu_out = alu_in1 & alu_in2;
            default: begin
                alu_out = (alu_in2 >> alu_in1[4:0]) | (alu_in2 << (6'd32 - {1'b0, alu_in1[4:0]}));
                alu_c   = alu_out[31];
            end
        endcase
        alu_n = alu_out[31];
        alu_z = (alu_out == 32'b0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: result/flags straight from the arithmetic definition of each op.
    task automatic model(input logic [2:0] op, input logic s, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output logic wb, output logic err,
                         output logic [3:0] nf, output int lat);
        logic [64:0] sum;
        logic [63:0] rot;
        logic [31:0] r;
        logic        n, z, c, v, cin;
        logic [3:0]  keep;
        res = '0; wb = (op != 3'd6) && (op != 3'd7); err = (op == 3'd7);
        lat = (op == 3'd7) ? 1 : (op == 3'd5) ? 3 : 2;
        n = 0; z = 0; c = 0; v = 0; keep = 4'b0000; r = '0;
        case (op)
            3'd0, 3'd1: begin
                cin = (op == 3'd1) ? mflags[1] : 1'b0;
                sum = 65'(a[31:0]) + 65'(b[31:0]) + 65'(cin);
                r = sum[31:0]; c = sum[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd2, 3'd6: begin
                r = a[31:0] - b[31:0]; c = (a[31:0] >= b[31:0]);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd3: begin r = a[31:0] & b[31:0]; keep = 4'b0011; end
            3'd4: begin
                rot = {a[31:0], a[31:0]} >> (b % 64'd32);
                r = rot[31:0]; c = r[31]; keep = 4'b0001;
            end
            default: ;
        endcase
        if (op == 3'd5) begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[63:0]; n = res[63]; z = (res == 64'd0); c = sum[64];
            v = (a[63] == b[63]) && (res[63] != a[63]);
        end else begin
            res = {32'b0, r}; n = r[31]; z = (r == 32'd0);
        end
        nf = mflags;
        if (op != 3'd7 && (s || op == 3'd6)) nf = ({n, z, c, v} & ~keep) | (mflags & keep);
    endtask

    task automatic run_op(input logic [2:0] op, input logic s, input logic [63:0] a, input logic [63:0] b,
                          input int hold);
        logic [63:0] eres;
        logic        ewb, eerr;
        logic [3:0]  enf;
        int          lat, cyc, pass;
        logic [31:0] e1, e2;
        logic [1:0]  eop;
        logic        ec;
        model(op, s, a, b, eres, ewb, eerr, enf, lat);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op; cmd_s = s; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
        cmd_valid = 0; cmd_op = 3'($urandom); cmd_s = 1'($urandom);
        cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom};
        cyc = 1; pass = 0;
        @(negedge clk);
        while (!rsp_valid && cyc < 10) begin
            e1 = a[31:0]; e2 = b[31:0]; eop = 2'b00;
            ec = (op == 3'd1) ? mflags[1] : 1'b0;
            if (pass == 1) begin
                e1 = a[63:32]; e2 = b[63:32];
                ec = 1'((65'(a[31:0]) + 65'(b[31:0])) >> 32);
            end else if (op == 3'd2 || op == 3'd6) begin
                e1 = b[31:0]; e2 = a[31:0]; eop = 2'b01;
            end else if (op == 3'd3) begin
                eop = 2'b10;
            end else if (op == 3'd4) begin
                e1 = {27'b0, b[4:0]}; e2 = a[31:0]; eop = 2'b11;
            end
            chk("alu_in1", alu_in1, e1);
            chk("alu_in2", alu_in2, e2);
            chk("alu_op", alu_op, eop);
            chk("alu_carry", alu_carry, ec);
            chk("cmd_ready_exec", cmd_ready, 0);
            @(posedge clk); cyc++; pass++;
            @(negedge clk);
        end
        chk("latency", cyc, lat);
        chk("rsp_result", rsp_result, eres);
        chk("rsp_wb", rsp_wb, ewb);
        chk("rsp_err", rsp_err, eerr);
        chk("flag_nzcv", flag_nzcv, enf);
        chk("alu_quiet", {alu_in1, alu_in2, alu_carry, alu_op}, 0);
        mflags = enf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, eres);
            chk("hold_ready", cmd_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        mops = mops + 16'd1;
        @(negedge clk);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("rsp_valid_after", rsp_valid, 0);
        chk("ops_done", ops_done, mops);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; cmd_valid = 0; cmd_op = 0; cmd_s = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0;
        mflags = 4'b0000; mops = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp", {rsp_result, rsp_wb, rsp_err}, 0);
        chk("rst_flags", flag_nzcv, 4'b0000);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_alu", {alu_in1, alu_in2, alu_carry, alu_op}, 0);

        run_op(3'd0, 1, 64'd5, 64'd7, 0);
        run_op(3'd2, 1, 64'd3, 64'd3, 1);
        run_op(3'd1, 0, 64'd1, 64'd1, 0);
        run_op(3'd5, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0);
        run_op(3'd4, 0, 64'h8000_0001, 64'd33, 2);
        run_op(3'd2, 1, 64'h8000_0000, 64'd1, 0);
        run_op(3'd3, 1, 64'hF0, 64'h0F, 0);
        run_op(3'd7, 1, 64'd9, 64'd9, 0);
        run_op(3'd6, 0, 64'd1, 64'd2, 0);
        run_op(3'd0, 0, 64'd11, 64'd22, 5);

        // Reset while the high pass of an ADD64 is in flight.
        @(negedge clk);
        cmd_valid = 1; cmd_op = 3'd5; cmd_s = 1; cmd_a = 64'hFFFF_FFFF_FFFF_FFFF; cmd_b = 64'd1;
        @(posedge clk); #1 cmd_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_hi_carry", alu_carry, 1);
        reset = 1;
        @(posedge clk); #1 reset = 0;
        mflags = 4'b0000; mops = 0;
        @(negedge clk);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_flags", flag_nzcv, 4'b0000);
        chk("midrst_ops_done", ops_done, 0);
        chk("midrst_alu", {alu_in1, alu_in2, alu_carry, alu_op}, 0);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end

        for (int i = 0; i < 60; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra[31:0] = 32'hFFFF_FFFF;
                2: rb = 64'd0;
                default: ;
            endcase
            run_op(3'($urandom_range(0, 7)), 1'($urandom), ra, rb, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
